apu_dmc: RTL and testbench
==========================

# apu_dmc

Delta modulation channel (DMC) for the APU. It fetches 1-bit delta sample bytes from CPU memory through a request/acknowledge port and turns them into a 7-bit output level. That level is `dmc_out`, the DMC term of the mixer's triangle/noise/DMC table index (3·tri + 2·noise + dmc). The block also provides the DMC IRQ flag and the bit-4 "active" status for the $4015 register.

## Interface
- No parameters. Rate table and address constants come from `apu_pkg`.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `cpu_tick`  in  1  one-cycle enable, one pulse per APU CPU cycle (1.789773 MHz)
- `reg_we`  in  1  write strobe for $4010–$4013
- `reg_addr`  in  2  register select: 0=$4010, 1=$4011, 2=$4012, 3=$4013
- `reg_wdata`  in  8  write data
- `enable_we`  in  1  $4015 write strobe
- `enable_wdata`  in  1  $4015 bit 4
- `mem_req`  out  1  fetch request, level signal
- `mem_addr`  out  16  fetch address, stable while `mem_req`=1
- `mem_ack`  in  1  fetch complete; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  8  fetched byte
- `dmc_out`  out  7  output level, 0–127
- `active`  out  1  1 while bytes_remaining ≠ 0
- `irq`  out  1  DMC interrupt flag

## Operation
- **$4010:** `irq_en`=d[7], `loop`=d[6], `rate_idx`=d[3:0]. A write with d[7]=0 clears `irq`.
- **$4011:** output level = d[6:0].
- **$4012:** sample start = 16'hC000 + d·64.
- **$4013:** sample length = d·16 + 1 bytes.
- **$4015 write (`enable_we`):**
  - Always clears `irq`.
  - bit=0 sets bytes_remaining to 0.
  - bit=1 with bytes_remaining=0 restarts: cur_addr=start, bytes_remaining=length.
  - bit=1 with bytes_remaining≠0 has no effect.
- **Timer:** counts down on `cpu_tick`. At 0 it reloads `DMC_RATE[rate_idx]-1` and issues one output clock.
- **Output unit:** 3-bit bits_remaining, 8-bit shift register, silence flag. On each output clock:
  - If not silent: shift[0]=1 raises the level by 2 only when level ≤ 125; shift[0]=0 lowers it by 2 only when level ≥ 2. Otherwise the level is unchanged.
  - Shift right by one, then decrement bits_remaining.
  - On reaching 0: reload to 8. If the buffer is full, move it into shift, mark the buffer empty, and clear silence. Otherwise set silence.
- **Reader FSM, states IDLE → FETCH → IDLE:**
  - IDLE→FETCH when the buffer is empty and bytes_remaining ≠ 0.
  - In FETCH, `mem_req`=1 and `mem_addr`=cur_addr.
  - On `mem_ack`:
    - Buffer = `mem_rdata`; buffer marked full.
    - cur_addr increments, with 16'hFFFF wrapping to 16'h8000.
    - bytes_remaining decrements. If it reaches 0: with `loop`, restart from start/length; otherwise, if `irq_en`, set `irq`.
    - Return to IDLE.
- **Conflict and boundary rules:**
  - A $4011 write in the same cycle as an output clock: the $4011 value wins.
  - Disabling via $4015 during FETCH does not abort the fetch. The byte lands in the buffer, bytes_remaining stays 0, and no IRQ is raised.
  - A $4010 write changes the period only at the next timer reload.
  - `reset` during FETCH drops `mem_req` immediately. The memory side ignores the abandoned request.

## Timing
- **Reset values:**
  - Outputs: `dmc_out`=0, `irq`=0, `active`=0, `mem_req`=0, `mem_addr`=16'hC000.
  - Internal state: rate_idx=0, timer=427, bits_remaining=8, silence=1, buffer empty, bytes_remaining=0, all register fields 0.
- Register writes take effect on the next clock edge. `dmc_out` is updated 1 cycle after the writing strobe.
- `dmc_out` is registered and changes the cycle after the `cpu_tick` that produced the output clock.
- `mem_req` rises 1 cycle after the buffer becomes empty, or after the restart that makes bytes_remaining nonzero.
- `mem_req` falls in the cycle after `mem_ack`. `mem_ack` is ignored while `mem_req`=0. The ack may arrive any number of cycles after the request, including the first cycle.
- `active` and `irq` update in the cycle after their causing event.

## Structure
- **`apu_pkg`:**
  - `DMC_RATE_NTSC[16]` (9-bit): 428,380,340,320,286,254,226,214,190,160,142,128,106,84,72,54.
  - `DMC_ADDR_BASE`=16'hC000 and `DMC_ADDR_WRAP`=16'h8000.
  - Register offset constants, shared with the APU register decoder.
- **Sub-module `apu_divider_tick`:** reloadable down-counter with enable, used for the DMC timer. It is reused by the frame sequencer.

## Test plan
- **Reset:** assert `reset` mid-fetch → next cycle `mem_req`=0, `dmc_out`=0, `irq`=0, `active`=0, `mem_addr`=C000.
- **Direct load:** write $4011=0x40 → `dmc_out`=64 one cycle later. Issue the write coincident with an output clock → `dmc_out` is still 64.
- **Single-byte playback:**
  - Setup: $4010=0x8F, $4012=0, $4013=0, $4011=64, then enable. Memory returns 0xFF at C000.
  - One fetch is issued to C000, after which `active`=0 and `irq`=1.
  - After the silent cycle, 8 output clocks 54 ticks apart raise `dmc_out` to 80.
- **Clamping:** level 126 with byte 0xFF → stays 126. Level 1 with byte 0x00 → stays 1.
- **Loop and address wrap:**
  - Setup: $4010=0x4F, $4012=0xFF, $4013=0x04.
  - Fetches FFC0..FFFF, then 8000, then restart at FFC0.
  - `irq` never set; `active` stays 1.
- **Disable:** enable=0 during FETCH → ack accepted, `active`=0, `irq` cleared, no further `mem_req`. Re-enable → fetch restarts at start.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU constants: DMC rate table, sample address constants, register offsets.
package apu_pkg;

  localparam logic [15:0] DMC_ADDR_BASE = 16'hC000;
  localparam logic [15:0] DMC_ADDR_WRAP = 16'h8000;

  // Offsets within the $4010-$4013 window, shared with the APU register decoder
  localparam logic [1:0] DMC_REG_CTRL  = 2'd0;
  localparam logic [1:0] DMC_REG_DLOAD = 2'd1;
  localparam logic [1:0] DMC_REG_ADDR  = 2'd2;
  localparam logic [1:0] DMC_REG_LEN   = 2'd3;

  localparam logic [8:0] DMC_RATE_NTSC [16] = '{
    9'd428, 9'd380, 9'd340, 9'd320, 9'd286, 9'd254, 9'd226, 9'd214,
    9'd190, 9'd160, 9'd142, 9'd128, 9'd106, 9'd84,  9'd72,  9'd54
  };

  typedef enum logic {
    DMC_IDLE,
    DMC_FETCH
  } dmc_rd_state_e;

  function automatic logic [15:0] dmc_next_addr(input logic [15:0] a);
    return (a == 16'hFFFF) ? DMC_ADDR_WRAP : a + 16'd1;
  endfunction

  function automatic logic [15:0] dmc_start_addr(input logic [7:0] d);
    return DMC_ADDR_BASE + {2'b00, d, 6'b00_0000};
  endfunction

  function automatic logic [11:0] dmc_length(input logic [7:0] d);
    return {d, 4'b0000} + 12'd1;
  endfunction

endpackage

// File: rtl/apu_dmc_if.sv
// DMC sample-fetch port: level request with address, single-cycle acknowledge with data.
interface apu_dmc_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/apu_divider_tick.sv
// Reloadable down-counter: on each enable it decrements, and at zero it reloads and ticks.
module apu_divider_tick #(
  parameter int unsigned          WIDTH     = 9,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] reload_val,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  assign tick = en && (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (en) begin
      count <= (count == '0) ? reload_val : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/apu_dmc.sv
// APU delta modulation channel: sample reader, rate timer and 1-bit delta output unit.
module apu_dmc
  import apu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_tick,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        enable_we,
  input  logic        enable_wdata,
  apu_dmc_if.master   mem,
  output logic [6:0]  dmc_out,
  output logic        active,
  output logic        irq
);

  logic          irq_en, loop_en;
  logic [3:0]    rate_idx;
  logic [7:0]    addr_reg, len_reg;
  logic [15:0]   cur_addr;
  logic [11:0]   bytes_rem;
  logic [7:0]    sample_buf;
  logic          buf_full;
  dmc_rd_state_e rd_state;

  logic [2:0]    bits_rem;
  logic [7:0]    shift_reg;
  logic          silence;
  logic [6:0]    level;
  logic          out_clk;
  logic          buf_take;

  apu_divider_tick #(.WIDTH(9), .RESET_VAL(9'd427)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (cpu_tick),
    .reload_val (DMC_RATE_NTSC[rate_idx] - 9'd1),
    .tick       (out_clk)
  );

  // bits_rem == 0 encodes a full count of 8, so a decrement from 1 closes the byte
  assign buf_take = out_clk && (bits_rem == 3'd1) && buf_full;
  assign active   = (bytes_rem != '0);
  assign dmc_out  = level;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state     <= DMC_IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= DMC_ADDR_BASE;
      cur_addr     <= DMC_ADDR_BASE;
      bytes_rem    <= '0;
      sample_buf   <= '0;
      buf_full     <= 1'b0;
      irq          <= 1'b0;
      irq_en       <= 1'b0;
      loop_en      <= 1'b0;
      rate_idx     <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
    end else begin
      case (rd_state)
        DMC_IDLE: begin
          if (!buf_full && bytes_rem != '0) begin
            rd_state     <= DMC_FETCH;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= cur_addr;
          end
        end
        DMC_FETCH: begin
          if (mem.mem_ack) begin
            rd_state    <= DMC_IDLE;
            mem.mem_req <= 1'b0;
            sample_buf  <= mem.mem_rdata;
            buf_full    <= 1'b1;
            cur_addr    <= dmc_next_addr(cur_addr);
            // A fetch finishing after a disable leaves bytes_rem at zero and raises nothing
            if (bytes_rem == 12'd1) begin
              if (loop_en) begin
                cur_addr  <= dmc_start_addr(addr_reg);
                bytes_rem <= dmc_length(len_reg);
              end else begin
                bytes_rem <= '0;
                if (irq_en) irq <= 1'b1;
              end
            end else if (bytes_rem != '0) begin
              bytes_rem <= bytes_rem - 12'd1;
            end
          end
        end
        default: rd_state <= DMC_IDLE;
      endcase

      if (buf_take) buf_full <= 1'b0;

      if (reg_we) begin
        case (reg_addr)
          DMC_REG_CTRL: begin
            irq_en   <= reg_wdata[7];
            loop_en  <= reg_wdata[6];
            rate_idx <= reg_wdata[3:0];
            if (!reg_wdata[7]) irq <= 1'b0;
          end
          DMC_REG_ADDR: addr_reg <= reg_wdata;
          DMC_REG_LEN:  len_reg  <= reg_wdata;
          default: ;
        endcase
      end

      if (enable_we) begin
        irq <= 1'b0;
        if (!enable_wdata) begin
          bytes_rem <= '0;
        end else if (bytes_rem == '0) begin
          cur_addr  <= dmc_start_addr(addr_reg);
          bytes_rem <= dmc_length(len_reg);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level     <= '0;
      bits_rem  <= '0;
      shift_reg <= '0;
      silence   <= 1'b1;
    end else begin
      if (out_clk) begin
        if (!silence) begin
          if (shift_reg[0] && level <= 7'd125)       level <= level + 7'd2;
          else if (!shift_reg[0] && level >= 7'd2)  level <= level - 7'd2;
        end
        shift_reg <= {1'b0, shift_reg[7:1]};
        bits_rem  <= bits_rem - 3'd1;
        if (bits_rem == 3'd1) begin
          if (buf_full) begin
            shift_reg <= sample_buf;
            silence   <= 1'b0;
          end else begin
            silence   <= 1'b1;
          end
        end
      end
      // Direct load overrides any delta step landing on the same edge
      if (reg_we && reg_addr == DMC_REG_DLOAD) level <= reg_wdata[6:0];
    end
  end

endmodule

// File: tb/tb_apu_dmc.sv
// Scoreboard bench for apu_dmc: a behavioural model predicts levels, flags and fetch addresses.
module tb_apu_dmc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_tick = 1'b0;
  logic       reg_we = 1'b0;
  logic [1:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic       enable_we = 1'b0;
  logic       enable_wdata = 1'b0;
  logic [6:0] dmc_out;
  logic       active;
  logic       irq;

  apu_dmc_if mem_if();

  apu_dmc dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_tick     (cpu_tick),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .enable_we    (enable_we),
    .enable_wdata (enable_wdata),
    .mem          (mem_if),
    .dmc_out      (dmc_out),
    .active       (active),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int lvl;
    bit irq;
    bit act;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];

  int RATE [16] = '{428, 380, 340, 320, 286, 254, 226, 214,
                    190, 160, 142, 128, 106, 84, 72, 54};

  // Behavioural model state
  int m_level, m_timer, m_rate, m_bits, m_shift, m_buf, m_bytes, m_addr, m_start, m_len;
  bit m_irq, m_sil, m_full, m_irq_en, m_loop, m_dis_fetch;

  bit mem_const_en = 1'b0;
  int mem_const = 0;
  bit req_seen = 1'b0;
  bit hold_ack = 1'b0;
  int ack_delay = 0;
  int n_fetch = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, expv, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_timer = 427; m_rate = 0; m_bits = 8; m_shift = 0; m_buf = 0;
    m_bytes = 0; m_addr = 16'hC000; m_start = 16'hC000; m_len = 1;
    m_irq = 0; m_sil = 1; m_full = 0; m_irq_en = 0; m_loop = 0; m_dis_fetch = 0;
  endtask

  function automatic int next_addr(input int a);
    return (a == 16'hFFFF) ? 16'h8000 : a + 1;
  endfunction

  function automatic int mem_byte(input int a);
    return mem_const_en ? mem_const : ((a * 73 + (a >> 8) * 29 + 11) & 255);
  endfunction

  // Drives one clock's inputs, advances the model across that edge, queues expectations.
  task automatic step(input bit tk, input bit we = 0, input int ra = 0, input int wd = 0,
                      input bit ewe = 0, input bit ed = 0);
    bit ack, oc, old_full;
    int rd, old_bytes;
    exp_t e;
    ack = 0; rd = 0; oc = 0;
    if (mem_if.mem_req && !hold_ack) begin
      if (!req_seen) begin
        req_seen = 1;
        ack_delay = $urandom_range(0, 3);
      end
      if (ack_delay == 0) begin
        ack = 1;
        req_seen = 0;
      end else begin
        ack_delay--;
      end
    end
    if (ack) begin
      rd = mem_byte(m_addr);
      chk("fetch_allowed", int'(!m_full && (m_bytes != 0 || m_dis_fetch)), 1);
      addr_q.push_back(m_addr);
      n_fetch++;
    end
    cpu_tick = tk; reg_we = we; reg_addr = ra[1:0]; reg_wdata = wd[7:0];
    enable_we = ewe; enable_wdata = ed;
    mem_if.mem_ack = ack; mem_if.mem_rdata = rd[7:0];

    old_full = m_full;
    old_bytes = m_bytes;
    if (tk) begin
      if (m_timer == 0) begin
        m_timer = RATE[m_rate] - 1;
        oc = 1;
      end else begin
        m_timer--;
      end
    end
    if (oc) begin
      if (!m_sil) begin
        if (m_shift % 2 == 1) begin
          if (m_level <= 125) m_level += 2;
        end else if (m_level >= 2) begin
          m_level -= 2;
        end
      end
      m_shift = m_shift / 2;
      m_bits--;
      if (m_bits == 0) begin
        m_bits = 8;
        if (m_full) begin
          m_shift = m_buf; m_full = 0; m_sil = 0;
        end else begin
          m_sil = 1;
        end
      end
    end
    if (ack) begin
      m_buf = rd; m_full = 1; m_addr = next_addr(m_addr); m_dis_fetch = 0;
      if (m_bytes != 0) begin
        m_bytes--;
        if (m_bytes == 0) begin
          if (m_loop) begin
            m_addr = m_start; m_bytes = m_len;
          end else if (m_irq_en) begin
            m_irq = 1;
          end
        end
      end
    end
    if (we) begin
      case (ra)
        0: begin
          m_irq_en = wd[7]; m_loop = wd[6]; m_rate = wd & 15;
          if (!wd[7]) m_irq = 0;
        end
        1: m_level = wd & 127;
        2: m_start = 16'hC000 + (wd & 255) * 64;
        default: m_len = (wd & 255) * 16 + 1;
      endcase
    end
    if (ewe) begin
      m_irq = 0;
      if (!ed) begin
        if (!old_full && old_bytes != 0 && !ack) m_dis_fetch = 1;
        m_bytes = 0;
      end else if (old_bytes == 0) begin
        m_addr = m_start; m_bytes = m_len;
      end
    end
    if (oc || we || ewe || ack) begin
      e.cyc = cyc + 1; e.lvl = m_level; e.irq = m_irq; e.act = (m_bytes != 0);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int tick_pct);
    for (int i = 0; i < n; i++) step($urandom_range(1, 100) <= tick_pct);
  endtask

  task automatic wr(input int a, input int d);
    step(1'($urandom_range(0, 1)), 1, a, d);
  endtask

  task automatic en(input bit b);
    step(1'($urandom_range(0, 1)), 0, 0, 0, 1, b);
  endtask

  task automatic wr_at_oc(input int d);
    for (int i = 0; i < 600 && m_timer != 0; i++) step(1);
    step(1, 1, 1, d);
  endtask

  task automatic wait_req(input string nm, input int limit);
    int i;
    i = 0;
    while (!mem_if.mem_req && i < limit) begin
      step(1);
      i++;
    end
    if (!mem_if.mem_req) chk(nm, 0, 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          chk("stale_expectation", e.cyc, cyc);
        end else begin
          chk("dmc_out", int'(dmc_out), e.lvl);
          chk("irq", int'(irq), int'(e.irq));
          chk("active", int'(active), int'(e.act));
        end
      end
      if (mem_if.mem_req && mem_if.mem_ack) begin
        if (addr_q.size() == 0) chk("fetch_addr_queued", 0, 1);
        else chk("mem_addr", int'(mem_if.mem_addr), addr_q.pop_front());
      end
    end
  end

  initial begin : stim
    int bad, base;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dmc_out", int'(dmc_out), 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_mem_req", int'(mem_if.mem_req), 0);
    chk("rst_mem_addr", int'(mem_if.mem_addr), 16'hC000);
    reset = 1'b0;

    // Direct load
    wr(1, 8'h40);
    chk("direct_load", int'(dmc_out), 64);

    // Single byte, IRQ enabled, fastest rate, all-ones sample
    mem_const_en = 1; mem_const = 8'hFF;
    wr(0, 8'h8F); wr(2, 0); wr(3, 0); wr(1, 64); en(1);
    run(2000, 100);
    chk("single_level", int'(dmc_out), 80);
    chk("single_active", int'(active), 0);
    chk("single_irq", int'(irq), 1);

    // Clamping at both ends
    wr(0, 8'h0F); wr(1, 126); en(1);
    run(2000, 100);
    chk("clamp_high", int'(dmc_out), 126);
    mem_const = 0;
    wr(1, 1); en(1);
    run(2000, 100);
    chk("clamp_low", int'(dmc_out), 1);

    // Looping sample crossing the FFFF -> 8000 wrap
    mem_const_en = 0;
    wr(0, 8'h4F); wr(2, 8'hFF); wr(3, 8'h04); en(1);
    base = n_fetch;
    for (int i = 0; i < 40000 && n_fetch < base + 68; i++) step(1);
    chk("loop_fetches", int'(n_fetch >= base + 68), 1);
    wr_at_oc(8'h40);
    chk("dload_vs_outclk", int'(dmc_out), 64);
    chk("loop_irq", int'(irq), 0);
    chk("loop_active", int'(active), 1);

    // Disable while a fetch is outstanding
    hold_ack = 1;
    wait_req("req_before_disable", 1000);
    en(0);
    hold_ack = 0;
    run(10, 100);
    chk("dis_active", int'(active), 0);
    chk("dis_irq", int'(irq), 0);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (mem_if.mem_req) bad++;
    end
    chk("dis_no_req", bad, 0);
    en(1);
    wait_req("req_after_reenable", 1000);
    chk("reenable_addr", int'(mem_if.mem_addr), 16'hFFC0);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      wr(0, ($urandom_range(0, 3) << 6) | (12 + $urandom_range(0, 3)));
      wr(1, $urandom_range(0, 127));
      wr(2, $urandom_range(0, 255));
      wr(3, $urandom_range(0, 2));
      en(1);
      run(3000, 75);
      if (r % 2 == 1) wr_at_oc($urandom_range(0, 127));
      en(0);
      run(10, 75);
    end

    // Reset in the middle of a fetch
    wr(0, 8'h0F); wr(3, 2); en(1);
    hold_ack = 1;
    wait_req("req_before_reset", 1000);
    reset = 1'b1;
    cpu_tick = 0; reg_we = 0; enable_we = 0;
    mem_if.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_mem_req", int'(mem_if.mem_req), 0);
    chk("mid_rst_dmc_out", int'(dmc_out), 0);
    chk("mid_rst_irq", int'(irq), 0);
    chk("mid_rst_active", int'(active), 0);
    chk("mid_rst_mem_addr", int'(mem_if.mem_addr), 16'hC000);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    addr_q.delete();
    hold_ack = 0;
    req_seen = 0;
    wr(1, 8'h22);
    chk("post_rst_load", int'(dmc_out), 8'h22);
    run(500, 100);
    chk("post_rst_idle_req", int'(mem_if.mem_req), 0);

    step(0);
    step(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
